// File: rtl/i2c_byte_master.sv
// i2c_byte_master: byte-level open-drain I2C write master (START, 8 bits, ACK, HOLD, STOP).
// Define CLOCK_STRETCH_EN to let a slave holding SCL low stall the quarter divider.
module i2c_byte_master #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_en,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] tx_data,
  output logic       ready,
  output logic       tx_done,
  output logic       ack_err,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_i,
  input  logic       sda_i
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DMAX = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, START, LATCH, BIT, ACK, HOLD, RSTART, STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          load_q, load_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          scl_q, scl_d;
  logic          sda_q, sda_d;

  logic          freeze;
  logic          tick;
  logic          accept;
  logic [7:0]    byte_now;

`ifdef CLOCK_STRETCH_EN
  assign freeze = !scl_q && !scl_i;
`else
  logic unused_scl_i;
  assign unused_scl_i = scl_i;
  assign freeze = 1'b0;
`endif

  assign tick     = !freeze && (cnt_q == DMAX);
  assign accept   = i2c_en && ready_q;
  // From HOLD the byte register and the first tick share one edge.
  assign byte_now = load_q ? tx_data : shift_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = freeze ? cnt_q : (tick ? '0 : cnt_q + 1'b1);
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    load_d  = 1'b0;
    ready_d = ready_q;
    done_d  = 1'b0;
    err_d   = err_q;
    busy_d  = busy_q;
    scl_d   = scl_q;
    sda_d   = sda_q;
    if (load_q) shift_d = tx_data;

    unique case (state_q)
      IDLE: begin
        if (accept && !stop) begin
          state_d = START;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          load_d  = 1'b1;
          cnt_d   = '0;
          qtr_d   = 2'd0;
        end
      end
      HOLD: begin
        if (accept) begin
          ready_d = 1'b0;
          qtr_d   = 2'd0;
          cnt_d   = '0;
          if (stop) begin
            state_d = STOP;
          end else if (start) begin
            state_d = RSTART;
            load_d  = 1'b1;
            err_d   = 1'b0;
          end else begin
            state_d = LATCH;
            load_d  = 1'b1;
            cnt_d   = DMAX;
          end
        end
      end
      START: begin
        if (tick) begin
          unique case (qtr_q)
            2'd0: begin sda_d = 1'b1; qtr_d = 2'd1; end
            2'd1: qtr_d = 2'd2;
            2'd2, 2'd3: begin
              scl_d   = 1'b1;
              state_d = LATCH;
            end
          endcase
        end
      end
      LATCH: begin
        if (tick) begin
          sda_d   = ~byte_now[7];
          shift_d = byte_now;
          bit_d   = 3'd0;
          qtr_d   = 2'd0;
          state_d = BIT;
        end
      end
      BIT: begin
        if (tick) begin
          unique case (qtr_q)
            2'd0: qtr_d = 2'd1;
            2'd1: begin scl_d = 1'b0; qtr_d = 2'd2; end
            2'd2: qtr_d = 2'd3;
            2'd3: begin
              scl_d = 1'b1;
              qtr_d = 2'd0;
              if (bit_q == 3'd7) begin
                sda_d   = 1'b0;
                state_d = ACK;
              end else begin
                bit_d   = bit_q + 3'd1;
                shift_d = {shift_q[6:0], 1'b0};
                sda_d   = ~shift_q[6];
              end
            end
          endcase
        end
      end
      ACK: begin
        if (tick) begin
          unique case (qtr_q)
            2'd0: qtr_d = 2'd1;
            2'd1: begin scl_d = 1'b0; qtr_d = 2'd2; end
            2'd2: begin
              qtr_d = 2'd3;
              if (sda_i) err_d = 1'b1;
            end
            2'd3: begin
              scl_d   = 1'b1;
              done_d  = 1'b1;
              ready_d = 1'b1;
              qtr_d   = 2'd0;
              state_d = HOLD;
            end
          endcase
        end
      end
      RSTART: begin
        if (tick) begin
          unique case (qtr_q)
            2'd0: begin sda_d = 1'b0; qtr_d = 2'd1; end
            2'd1: begin scl_d = 1'b0; qtr_d = 2'd2; end
            2'd2: begin sda_d = 1'b1; qtr_d = 2'd3; end
            2'd3: begin
              scl_d   = 1'b1;
              qtr_d   = 2'd0;
              state_d = LATCH;
            end
          endcase
        end
      end
      STOP: begin
        if (tick) begin
          unique case (qtr_q)
            2'd0: begin sda_d = 1'b1; qtr_d = 2'd1; end
            2'd1: begin scl_d = 1'b0; qtr_d = 2'd2; end
            2'd2: begin sda_d = 1'b0; qtr_d = 2'd3; end
            2'd3: begin
              busy_d  = 1'b0;
              ready_d = 1'b1;
              qtr_d   = 2'd0;
              state_d = IDLE;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      qtr_q   <= 2'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      load_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      scl_q   <= 1'b0;
      sda_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      load_q  <= load_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
    end
  end

  assign ready   = ready_q;
  assign tx_done = done_q;
  assign ack_err = err_q;
  assign busy    = busy_q;
  assign scl_oe  = scl_q;
  assign sda_oe  = sda_q;

endmodule

// File: tb/tb_i2c_byte_master.sv
// tb_i2c_byte_master: directed bench for the I2C byte master at CLK_DIV=4.
// The slave pulls SDA low throughout (always ACKs) unless slave_low is cleared.
`timescale 1ns/1ps
module tb_i2c_byte_master;

  localparam int DIV    = 4;
  // accept edge to tx_done edge: HOLD = latch clk + 36 quarters
  localparam int L_HOLD = 1 + 36 * DIV;
  // IDLE adds 3 START quarters plus the LATCH quarter
  localparam int L_IDLE = 4 * DIV + 36 * DIV;
  // repeated START: 4 RSTART quarters plus the LATCH quarter
  localparam int L_RST  = 5 * DIV + 36 * DIV;
  localparam int L_STOP = 4 * DIV;
`ifdef CLOCK_STRETCH_EN
  localparam int STRETCH = 20;
`else
  localparam int STRETCH = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i2c_en = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ready, tx_done, ack_err, busy;
  logic       scl_oe, sda_oe, scl_i, sda_i;
  logic       slave_low = 1'b1;
  logic       stretch = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc = 0;
  int rises = 0;
  int starts = 0;
  int stops = 0;
  int dones = 0;
  int arm_at = -1;
  int str_left = 0;
  int st_b = 0;
  int sp_b = 0;
  int dn_b = 0;
  logic [8:0] last9 = 9'd0;
  logic prev_scl = 1'b0;
  logic prev_sda = 1'b0;

  assign scl_i = ~scl_oe & ~stretch;
  assign sda_i = ~sda_oe & ~slave_low;

  i2c_byte_master #(.CLK_DIV(DIV)) dut (
    .clk     (clk),
    .reset   (reset),
    .i2c_en  (i2c_en),
    .start   (start),
    .stop    (stop),
    .tx_data (tx_data),
    .ready   (ready),
    .tx_done (tx_done),
    .ack_err (ack_err),
    .busy    (busy),
    .scl_oe  (scl_oe),
    .sda_oe  (sda_oe),
    .scl_i   (scl_i),
    .sda_i   (sda_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: bits on SCL rises, START/STOP conditions, tx_done pulses.
  always @(negedge clk) begin
    if (str_left > 0) begin
      str_left--;
      if (str_left == 0) stretch = 1'b0;
    end
    if (prev_scl && !scl_oe) begin
      rises++;
      last9 = {last9[7:0], ~sda_oe};
      if (rises == arm_at) begin
        stretch  = 1'b1;
        str_left = 20;
        arm_at   = -1;
      end
    end
    if (!scl_oe && !prev_scl && !prev_sda && sda_oe) starts++;
    if (!scl_oe && !prev_scl && prev_sda && !sda_oe) stops++;
    if (tx_done) dones++;
    prev_scl = scl_oe;
    prev_sda = sda_oe;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic st, input logic sp);
    i2c_en = 1'b1;
    start  = st;
    stop   = sp;
    step();
    i2c_en  = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    tx_data = b;
    acc     = cyc;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int n = 0;
    while (!tx_done && n < 400) begin
      step();
      n++;
    end
    chk(tag, cyc - acc, exp_lat);
  endtask

  task automatic wait_ready(input string tag, input int exp_lat);
    int n = 0;
    while (!ready && n < 400) begin
      step();
      n++;
    end
    chk(tag, cyc - acc, exp_lat);
  endtask

  initial begin
    repeat (3) step();
    chk("reset_state", {scl_oe, sda_oe, ready, tx_done, ack_err, busy},
        6'b001000);
    reset = 1'b0;
    step();

    // single byte from IDLE
    send(8'hAA, 1'b0, 1'b0);
    chk("accept_ready_low", {ready, busy}, 2'b01);
    wait_done("lat_idle_AA", L_IDLE);
    chk("bits_AA", last9, {8'hAA, 1'b1});
    chk("start_seen", starts, 1);
    chk("ack_ok_AA", ack_err, 1'b0);
    step();
    chk("done_pulse", {tx_done, ready, scl_oe, busy}, 4'b0111);
    repeat (20) step();
    chk("hold_scl_low", {scl_oe, ready}, 2'b11);

    // rest of the frame; a busy-time i2c_en+stop must be ignored
    send(8'h00, 1'b0, 1'b0);
    repeat (8) step();
    i2c_en = 1'b1;
    stop   = 1'b1;
    step();
    i2c_en = 1'b0;
    stop   = 1'b0;
    wait_done("lat_hold_00", L_HOLD);
    chk("bits_00", last9, {8'h00, 1'b1});
    send(8'hC0, 1'b0, 1'b0);
    wait_done("lat_hold_C0", L_HOLD);
    chk("bits_C0", last9, {8'hC0, 1'b1});
    send(8'h5F, 1'b0, 1'b0);
    wait_done("lat_hold_5F", L_HOLD);
    chk("bits_5F", last9, {8'h5F, 1'b1});
    chk("frame_dones", dones, 4);
    send(8'h00, 1'b0, 1'b1);
    wait_ready("lat_stop", L_STOP);
    chk("stop_seen", stops, 1);
    chk("idle_after_stop", {busy, ready, scl_oe, sda_oe, tx_done}, 5'b01000);
    chk("no_done_on_stop", dones, 4);

    // NACK on byte 2 is sticky until the next START
    send(8'h11, 1'b0, 1'b0);
    wait_done("lat_idle_11", L_IDLE);
    chk("ack_ok_11", ack_err, 1'b0);
    slave_low = 1'b0;
    send(8'h22, 1'b0, 1'b0);
    wait_done("lat_hold_22", L_HOLD);
    chk("nack_flag", ack_err, 1'b1);
    slave_low = 1'b1;
    send(8'h33, 1'b0, 1'b0);
    wait_done("lat_hold_33", L_HOLD);
    chk("nack_sticky", ack_err, 1'b1);
    send(8'h00, 1'b0, 1'b1);
    wait_ready("lat_stop2", L_STOP);
    chk("nack_after_stop", ack_err, 1'b1);
    send(8'h44, 1'b0, 1'b0);
    chk("nack_clr_on_start", ack_err, 1'b0);
    wait_done("lat_idle_44", L_IDLE);

    // start+stop in HOLD gives STOP only
    st_b = starts;
    sp_b = stops;
    dn_b = dones;
    send(8'h00, 1'b1, 1'b1);
    wait_ready("lat_stop_both", L_STOP);
    chk("both_no_start", starts, st_b);
    chk("both_stop", stops, sp_b + 1);
    chk("both_no_done", dones, dn_b);

    // stop in IDLE is a no-op
    i2c_en = 1'b1;
    stop   = 1'b1;
    step();
    i2c_en = 1'b0;
    stop   = 1'b0;
    chk("idle_stop_noop", {ready, busy}, 2'b10);
    repeat (10) step();
    chk("idle_lines_free", {scl_oe, sda_oe, busy}, 3'b000);

    // repeated START, with SCL stretched 20 clk in bit 3
    send(8'h81, 1'b0, 1'b0);
    wait_done("lat_idle_81", L_IDLE);
    st_b   = starts;
    arm_at = rises + 5;
    send(8'h3C, 1'b1, 1'b0);
    wait_done("lat_rstart_3C", L_RST + STRETCH);
    chk("rstart_seen", starts, st_b + 1);
    chk("bits_3C", last9, {8'h3C, 1'b1});
    send(8'h00, 1'b0, 1'b1);
    wait_ready("lat_stop3", L_STOP);

    // asynchronous reset in the middle of bit 1
    send(8'h0F, 1'b0, 1'b0);
    repeat (36) step();
    chk("pre_reset_bus", {scl_oe, sda_oe, ready, busy}, 4'b1101);
    reset = 1'b1;
    #1;
    chk("async_reset", {scl_oe, sda_oe, ready, busy, tx_done}, 5'b00100);
    step();
    reset = 1'b0;
    step();
    st_b = starts;
    send(8'h5A, 1'b0, 1'b0);
    wait_done("lat_after_reset", L_IDLE);
    chk("start_after_reset", starts, st_b + 1);
    chk("bits_5A", last9, {8'h5A, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
